// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-pending scoreboard for the in-order pipeline. Every long-latency
// write (load, mul, div) marks its destination pending from issue until its
// writeback. The instruction in ID is stalled on a RAW or WAW conflict against
// a pending register, or when the in-flight limit has been reached.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_valid              valid instruction in IF/ID
//   id_rs1, id_rs2        source register indices
//   id_rs1_used/rs2_used  source field actually read
//   id_rd, id_rd_we       destination index and write enable
//   id_long               instruction is long-latency
//   flush                 squash the instruction in ID
//   wb_valid, wb_rd       long-latency writeback this cycle
//   stall                 hold PC and IF/ID, bubble into ID/EX (combinational)
//   pend_cnt              long-latency operations in flight
//   full                  pend_cnt == MAX_PEND
//   stall_cycles          saturating count of stalled cycles
//   err                   sticky: writeback to a non-pending register or x0
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int unsigned NREG     = 32,
   parameter int unsigned AW       = 5,
   parameter int unsigned MAX_PEND = 4,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned PW      = $clog2(MAX_PEND + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [AW-1:0]    id_rd,
   input  logic             id_rd_we,
   input  logic             id_long,
   input  logic             flush,
   input  logic             wb_valid,
   input  logic [AW-1:0]    wb_rd,
   output logic             stall,
   output logic [PW-1:0]    pend_cnt,
   output logic             full,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             err
);

   localparam logic [PW-1:0]    CntMax   = PW'(MAX_PEND);
   localparam logic [CNT_W-1:0] StallMax = '1;

   // State
   logic [NREG-1:0]  pending_q, pending_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0] sc_q, sc_d;
   logic             err_q, err_d;

   // One-hot decodes. Bit 0 is never set, so register 0 can never match a
   // pending bit and indices outside NREG decode to nothing.
   logic [NREG-1:0] rs1_dec, rs2_dec, rd_dec, wb_dec;

   always_comb begin
      rs1_dec = '0;
      rs2_dec = '0;
      rd_dec  = '0;
      wb_dec  = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         rs1_dec[r] = (id_rs1 == AW'(r));
         rs2_dec[r] = (id_rs2 == AW'(r));
         rd_dec[r]  = (id_rd  == AW'(r));
         wb_dec[r]  = (wb_rd  == AW'(r));
      end
   end

   // Hazard evaluation
   logic [NREG-1:0] eff;
   logic            wb_clear;
   logic            long_wr;
   logic            raw1, raw2, waw, cap;
   logic            at_max;
   logic            issue;

   always_comb begin
      // A same-cycle writeback is bypassed WB->ID, so it no longer blocks.
      eff      = pending_q & ~(wb_valid ? wb_dec : '0);
      wb_clear = wb_valid & (|(pending_q & wb_dec));
      long_wr  = id_long & id_rd_we & (|rd_dec);
      raw1     = id_rs1_used & (|(eff & rs1_dec));
      raw2     = id_rs2_used & (|(eff & rs2_dec));
      waw      = id_rd_we & (|(eff & rd_dec));
      at_max   = (cnt_q >= CntMax);
      // cnt never exceeds MAX_PEND, so "cnt - clear >= MAX_PEND" reduces to
      // "at the limit and nothing retiring this cycle".
      cap      = long_wr & at_max & ~wb_clear;
      stall    = id_valid & ~flush & (raw1 | raw2 | waw | cap);
      issue    = id_valid & ~flush & ~stall & long_wr;
   end

   // Next state
   always_comb begin
      pending_d = pending_q;
      if (wb_clear) begin
         pending_d = pending_d & ~wb_dec;
      end
      // Applied after the clear so a same-register issue wins.
      if (issue) begin
         pending_d = pending_d | rd_dec;
      end

      cnt_d = cnt_q;
      unique case ({issue, wb_clear})
         2'b10: if (cnt_q < CntMax) cnt_d = cnt_q + PW'(1);
         2'b01: if (cnt_q != '0)    cnt_d = cnt_q - PW'(1);
         default: cnt_d = cnt_q;
      endcase

      // Any writeback that does not retire a pending register is a protocol
      // error; it leaves the bitmap and count untouched.
      err_d = err_q | (wb_valid & ~wb_clear);

      sc_d = sc_q;
      if (stall && (sc_q != StallMax)) begin
         sc_d = sc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         sc_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         sc_q      <= sc_d;
         err_q     <= err_d;
      end
   end

   assign pend_cnt     = cnt_q;
   assign full         = (cnt_q == CntMax);
   assign stall_cycles = sc_q;
   assign err          = err_q;

   // Invariants: the count always equals the bitmap population and x0 is
   // never pending.
   a_cnt_matches_bitmap: assert property (@(posedge clk) disable iff (!rst_n)
      $countones(pending_q) == int'(cnt_q));
   a_x0_never_pending: assert property (@(posedge clk) disable iff (!rst_n)
      !pending_q[0]);

endmodule
